// File: rtl/mem_io_pkg.sv
// Shared state encoding, default IO window addresses and IO decode helper
// for the SLC-3 memory/IO bridge.
package mem_io_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    localparam logic [15:0] DEF_IO_SW_HEX_ADDR = 16'hFFFF;
    localparam logic [15:0] DEF_IO_LED_ADDR    = 16'hFFFE;

    function automatic logic io_hit(input logic [31:0] a,
                                    input logic [31:0] sw_hex,
                                    input logic [31:0] led);
        return (a == sw_hex) || (a == led);
    endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU request/ack handshake, async SRAM bus and board IO of the memory/IO bridge.
interface mem_io_ctrl_if #(
    parameter int CPU_ADDR_W  = 16,
    parameter int SRAM_ADDR_W = 20,
    parameter int NUM_HEX     = 4,
    parameter int LED_W       = 12
);
    logic                   req;
    logic                   we;
    logic [1:0]             be;
    logic [CPU_ADDR_W-1:0]  addr;
    logic [15:0]            wdata;
    logic [15:0]            rdata;
    logic                   ack;
    logic                   busy;
    logic                   CE;
    logic                   OE;
    logic                   WE;
    logic                   UB;
    logic                   LB;
    logic [SRAM_ADDR_W-1:0] ADDR;
    logic [15:0]            Data_to_SRAM;
    logic                   Data_oe;
    logic [15:0]            Data_from_SRAM;
    logic [15:0]            Switches;
    logic [NUM_HEX*4-1:0]   hex_out;
    logic [LED_W-1:0]       LED;

    modport slave (
        input  req, we, be, addr, wdata, Data_from_SRAM, Switches,
        output rdata, ack, busy, CE, OE, WE, UB, LB, ADDR, Data_to_SRAM, Data_oe,
               hex_out, LED
    );

    modport master (
        output req, we, be, addr, wdata, Data_from_SRAM, Switches,
        input  rdata, ack, busy, CE, OE, WE, UB, LB, ADDR, Data_to_SRAM, Data_oe,
               hex_out, LED
    );
endinterface

// File: rtl/mem_io_sram_seq.sv
// Access sequencer: state register, wait counter and registered SRAM strobes.
// Strobes are computed from the next state so they line up with the state they belong to.
module mem_io_sram_seq
    import mem_io_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_go_sram,
    input  logic       i_go_io,
    input  logic       i_we,
    input  logic [1:0] i_be,
    output logic       o_idle,
    output logic       o_rd_cap,
    output logic       o_ack,
    output logic       o_busy,
    output logic       o_ce_n,
    output logic       o_oe_n,
    output logic       o_we_n,
    output logic       o_ub_n,
    output logic       o_lb_n,
    output logic       o_data_oe
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_we;
    logic [1:0] r_be;
    logic       w_we;
    logic [1:0] w_be;
    logic       w_ext;
    logic       w_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_go_io)        w_next = DONE;
                else if (i_go_sram) w_next = i_we ? SETUP : ACCESS;
            end
            SETUP:   w_next = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_next = r_we ? HOLD : DONE;
            HOLD:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // On the acceptance edge the latched copies are not yet valid, so use the request itself
    assign w_we     = (r_state == IDLE) ? i_we : r_we;
    assign w_be     = (r_state == IDLE) ? i_be : r_be;
    assign w_ext    = (w_next == SETUP) || (w_next == ACCESS) || (w_next == HOLD);
    assign w_acc    = (w_next == ACCESS);
    assign o_idle   = (r_state == IDLE);
    assign o_rd_cap = (r_state == ACCESS) && (r_cnt == 4'd0) && !r_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_be      <= 2'b00;
            o_ack     <= 1'b0;
            o_busy    <= 1'b0;
            o_ce_n    <= 1'b1;
            o_oe_n    <= 1'b1;
            o_we_n    <= 1'b1;
            o_ub_n    <= 1'b1;
            o_lb_n    <= 1'b1;
            o_data_oe <= 1'b0;
        end else begin
            r_state <= w_next;
            if (o_idle && (i_go_sram || i_go_io)) begin
                r_we <= i_we;
                r_be <= i_be;
            end
            if (w_acc && (r_state != ACCESS))
                r_cnt <= WAIT_INIT;
            else if ((r_state == ACCESS) && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            o_ack     <= (w_next == DONE);
            o_busy    <= (w_next != IDLE);
            o_ce_n    <= !w_ext;
            o_oe_n    <= !(w_acc && !w_we);
            o_we_n    <= !(w_acc && w_we);
            o_ub_n    <= !(w_acc && (!w_we || w_be[1]));
            o_lb_n    <= !(w_acc && (!w_we || w_be[0]));
            o_data_oe <= w_we && w_ext;
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// SLC-3 memory/IO bridge top: request decode, IO window registers, switch
// synchronizer and read-data register around the SRAM access sequencer.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int                    CPU_ADDR_W     = 16,
    parameter int                    SRAM_ADDR_W    = 20,
    parameter int                    WAIT_STATES    = 1,
    parameter int                    NUM_HEX        = 4,
    parameter int                    LED_W          = 12,
    parameter logic [CPU_ADDR_W-1:0] IO_SW_HEX_ADDR = CPU_ADDR_W'(DEF_IO_SW_HEX_ADDR),
    parameter logic [CPU_ADDR_W-1:0] IO_LED_ADDR    = CPU_ADDR_W'(DEF_IO_LED_ADDR)
) (
    input  logic         Clk,
    input  logic         Reset,
    mem_io_ctrl_if.slave bus
);
    logic                   w_idle;
    logic                   w_rd_cap;
    logic                   w_accept;
    logic                   w_io;
    logic                   w_hit_sw;
    logic                   w_ack;
    logic                   w_busy;
    logic                   w_ce_n;
    logic                   w_oe_n;
    logic                   w_we_n;
    logic                   w_ub_n;
    logic                   w_lb_n;
    logic                   w_data_oe;
    logic [15:0]            r_sw_s1;
    logic [15:0]            r_sw_s2;
    logic [15:0]            r_rdata;
    logic [15:0]            r_wdata;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [NUM_HEX*4-1:0]   r_hex;
    logic [LED_W-1:0]       r_led;

    assign w_accept = w_idle && bus.req;
    assign w_hit_sw = (bus.addr == IO_SW_HEX_ADDR);
    assign w_io     = io_hit(32'(bus.addr), 32'(IO_SW_HEX_ADDR), 32'(IO_LED_ADDR));

    mem_io_sram_seq #(
        .WAIT_STATES (WAIT_STATES)
    ) u_seq (
        .clk       (Clk),
        .rst       (Reset),
        .i_go_sram (w_accept && !w_io),
        .i_go_io   (w_accept && w_io),
        .i_we      (bus.we),
        .i_be      (bus.be),
        .o_idle    (w_idle),
        .o_rd_cap  (w_rd_cap),
        .o_ack     (w_ack),
        .o_busy    (w_busy),
        .o_ce_n    (w_ce_n),
        .o_oe_n    (w_oe_n),
        .o_we_n    (w_we_n),
        .o_ub_n    (w_ub_n),
        .o_lb_n    (w_lb_n),
        .o_data_oe (w_data_oe)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_rdata <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_hex   <= '0;
            r_led   <= '0;
        end else begin
            r_sw_s1 <= bus.Switches;
            r_sw_s2 <= r_sw_s1;
            if (w_accept) begin
                r_addr  <= SRAM_ADDR_W'(bus.addr);
                r_wdata <= bus.wdata;
            end
            // IO accesses complete in one cycle, so their effect lands on the acceptance edge
            if (w_accept && w_io) begin
                if (bus.we) begin
                    if (w_hit_sw) r_hex <= bus.wdata[NUM_HEX*4-1:0];
                    else          r_led <= bus.wdata[LED_W-1:0];
                end else begin
                    r_rdata <= w_hit_sw ? r_sw_s2 : 16'(r_led);
                end
            end
            if (w_rd_cap)
                r_rdata <= bus.Data_from_SRAM;
        end
    end

    assign bus.rdata        = r_rdata;
    assign bus.ack          = w_ack;
    assign bus.busy         = w_busy;
    assign bus.CE           = w_ce_n;
    assign bus.OE           = w_oe_n;
    assign bus.WE           = w_we_n;
    assign bus.UB           = w_ub_n;
    assign bus.LB           = w_lb_n;
    assign bus.ADDR         = r_addr;
    assign bus.Data_to_SRAM = r_wdata;
    assign bus.Data_oe      = w_data_oe;
    assign bus.hex_out      = r_hex;
    assign bus.LED          = r_led;

endmodule
